// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: read-tag encoding and default bus widths
// (the VGA timing generator uses the same widths).
package fb_pkg;

  localparam int FB_ADDR_W = 16;
  localparam int FB_DATA_W = 8;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_HOST = 2'd2
  } fb_tag_t;

endpackage

// File: rtl/fb_rd_tag_pipe.sv
// RD_LAT-deep shift register of read-owner tags, aligned with the RAM read
// latency, decoding which requester owns the data at the last stage.
module fb_rd_tag_pipe
  import fb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  fb_tag_t tag_in,
  output logic    disp_hit,
  output logic    host_hit
);

  fb_tag_t tag_last;

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      fb_tag_t tag_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) tag_reg <= TAG_NONE;
          else        tag_reg <= tag_in;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) tag_reg <= TAG_NONE;
          else        tag_reg <= g_stage[gi-1].tag_reg;
        end
      end
    end
  endgenerate

  assign tag_last = g_stage[RD_LAT-1].tag_reg;
  assign disp_hit = (tag_last == TAG_DISP);
  assign host_hit = (tag_last == TAG_HOST);

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM arbiter: display reads have absolute priority,
// host served in free cycles. Optional counters under FB_ARB_STATS_EN.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              clr_status,
  output logic              host_starved
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]       host_grant_cnt,
  output logic [15:0]       host_defer_cnt
`endif
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic             host_xfer;
  logic             host_stall;
  fb_tag_t          tag_in;
  logic             disp_hit;
  logic             host_hit;
  logic [CNT_W-1:0] starve_cnt_reg;
  logic [CNT_W-1:0] starve_cnt_next;
  logic             starve_set;

  // Gating with rst_n keeps a pending host write from reaching the RAM in reset.
  assign host_ready = rst_n & ~disp_req;
  assign host_xfer  = host_valid & host_ready;
  assign host_stall = host_valid & ~host_ready;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = host_addr;
    ram_wdata = host_wdata;
    tag_in    = TAG_NONE;
    if (disp_req) begin
      ram_en   = 1'b1;
      ram_addr = disp_addr;
      tag_in   = TAG_DISP;
    end else if (host_xfer) begin
      ram_en = 1'b1;
      ram_we = host_we;
      tag_in = host_we ? TAG_NONE : TAG_HOST;
    end
  end

  fb_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .tag_in   (tag_in),
    .disp_hit (disp_hit),
    .host_hit (host_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      disp_rdata  <= '0;
      host_rdata  <= '0;
    end else begin
      disp_rvalid <= disp_hit;
      host_rvalid <= host_hit;
      if (disp_hit) disp_rdata <= ram_rdata;
      if (host_hit) host_rdata <= ram_rdata;
    end
  end

  always_comb begin
    starve_cnt_next = '0;
    if (host_stall) begin
      if (starve_cnt_reg == CNT_W'(STARVE_MAX)) starve_cnt_next = starve_cnt_reg;
      else                                      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  assign starve_set = host_stall && (starve_cnt_next == CNT_W'(STARVE_MAX));

  // Set takes precedence over clr_status so an ongoing stall stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
      host_starved   <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      if (starve_set)      host_starved <= 1'b1;
      else if (clr_status) host_starved <= 1'b0;
    end
  end

`ifdef FB_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_grant_cnt <= '0;
      host_defer_cnt <= '0;
    end else begin
      if (clr_status)     host_grant_cnt <= '0;
      else if (host_xfer) host_grant_cnt <= host_grant_cnt + 16'd1;
      if (clr_status)      host_defer_cnt <= '0;
      else if (host_stall) host_defer_cnt <= host_defer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter (RD_LAT=2, STARVE_MAX=64) with a
// behavioural RAM; read returns are checked through a scoreboard queue.
module tb_fb_arbiter;
  import fb_pkg::*;

  localparam int AW         = 16;
  localparam int DW         = 8;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 64;

  logic          clk;
  logic          rst_n;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          host_valid;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ready;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          clr_status;
  logic          host_starved;
`ifdef FB_ARB_STATS_EN
  logic [15:0]   host_grant_cnt;
  logic [15:0]   host_defer_cnt;
`endif

  fb_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .RD_LAT     (RD_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .disp_req     (disp_req),
    .disp_addr    (disp_addr),
    .disp_rvalid  (disp_rvalid),
    .disp_rdata   (disp_rdata),
    .host_valid   (host_valid),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_ready   (host_ready),
    .host_rvalid  (host_rvalid),
    .host_rdata   (host_rdata),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .clr_status   (clr_status),
    .host_starved (host_starved)
`ifdef FB_ARB_STATS_EN
    ,
    .host_grant_cnt (host_grant_cnt),
    .host_defer_cnt (host_defer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with RD_LAT-clock read latency.
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [RD_LAT];

  function automatic logic [DW-1:0] init_val(input int a);
    logic [15:0] w;
    w = a[15:0];
    return w[7:0] ^ 8'h3C ^ {w[11:8], w[15:12]};
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        rd_pipe[0]    <= mem[ram_addr];
    end
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[RD_LAT-1];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic          is_disp;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sb[$];

  // Drive one request cycle (called at negedge) and record what must come back.
  task automatic drive(input logic dr, input logic [AW-1:0] da, input logic hv,
                       input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    exp_t e;
    disp_req   = dr;
    disp_addr  = da;
    host_valid = hv;
    host_we    = hw;
    host_addr  = ha;
    host_wdata = hd;
    e.due = cyc + 1 + RD_LAT;
    if (dr) begin
      e.is_disp = 1'b1;
      e.data    = exp_mem[da];
      sb.push_back(e);
    end else if (hv) begin
      if (hw) exp_mem[ha] = hd;
      else begin
        e.is_disp = 1'b0;
        e.data    = exp_mem[ha];
        sb.push_back(e);
      end
    end
    #1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rvalid_owner", {30'd0, disp_rvalid, host_rvalid}, e.is_disp ? 32'd2 : 32'd1);
      chk("rdata", e.is_disp ? {24'd0, disp_rdata} : {24'd0, host_rdata}, {24'd0, e.data});
      $display("cycle %0d: %s read data 0x%0h", cyc, e.is_disp ? "disp" : "host", e.data);
    end else if (disp_rvalid || host_rvalid) begin
      chk("spurious_rvalid", {30'd0, disp_rvalid, host_rvalid}, 32'd0);
    end
  end

  typedef struct {
    logic          dr;
    logic [AW-1:0] da;
    logic          hv;
    logic          hw;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    logic          e_ready;
    logic          e_en;
    logic          e_we;
    logic [AW-1:0] e_addr;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic dr, input logic [AW-1:0] da, input logic hv, input logic hw,
                     input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                     input logic er, input logic een, input logic ewe, input logic [AW-1:0] ea);
    vec_t v;
    v.dr = dr; v.da = da; v.hv = hv; v.hw = hw; v.ha = ha; v.hd = hd;
    v.e_ready = er; v.e_en = een; v.e_we = ewe; v.e_addr = ea;
    vt.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = init_val(i);
      exp_mem[i] = init_val(i);
    end
    rst_n = 1'b0; clr_status = 1'b0;
    disp_req = 1'b0; disp_addr = '0; host_valid = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0;

    //            dr  da       hv  hw  ha       hd     rdy en  we  addr
    add(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0012, 8'hA5, 1'b1, 1'b1, 1'b1, 16'h0012);
    add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0012, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0012);
    add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++)
      add(1'b1, 16'h0100, 1'b1, 1'b1, 16'h0003, 8'h5A, 1'b0, 1'b1, 1'b0, 16'h0100);
    add(1'b0, 16'h0100, 1'b1, 1'b1, 16'h0003, 8'h5A, 1'b1, 1'b1, 1'b1, 16'h0003);
    add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000);
    add(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0040);
    add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0041, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0041);
    add(1'b1, 16'h0042, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0042);
    add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0043, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0043);
    add(1'b1, 16'h0003, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0003);
    add(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0012, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0012);

    repeat (3) @(negedge clk);
    #1;
    chk("reset_host_ready", {31'd0, host_ready}, 32'd0);
    chk("reset_disp_rvalid", {31'd0, disp_rvalid}, 32'd0);
    chk("reset_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("reset_starved", {31'd0, host_starved}, 32'd0);
    chk("reset_rdata", {16'd0, disp_rdata, host_rdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].dr, vt[i].da, vt[i].hv, vt[i].hw, vt[i].ha, vt[i].hd);
      chk("host_ready", {31'd0, host_ready}, {31'd0, vt[i].e_ready});
      chk("ram_en", {31'd0, ram_en}, {31'd0, vt[i].e_en});
      if (vt[i].e_en) begin
        chk("ram_we", {31'd0, ram_we}, {31'd0, vt[i].e_we});
        chk("ram_addr", {16'd0, ram_addr}, {16'd0, vt[i].e_addr});
        if (vt[i].e_we) chk("ram_wdata", {24'd0, ram_wdata}, {24'd0, vt[i].hd});
      end
      @(negedge clk);
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    chk("drain_vectors", sb.size(), 32'd0);
    chk("ram_word_0003", {24'd0, mem[16'h0003]}, 32'h5A);
    chk("ram_word_0012", {24'd0, mem[16'h0012]}, 32'hA5);

    // Starvation: display hogs the RAM while the host waits.
    for (int i = 1; i <= STARVE_MAX; i++) begin
      drive(1'b1, AW'(16'h0080 + i), 1'b1, 1'b0, 16'h0050, 8'h00);
      @(negedge clk);
      if (i == STARVE_MAX - 1) chk("starved_before_max", {31'd0, host_starved}, 32'd0);
      if (i == STARVE_MAX)     chk("starved_at_max", {31'd0, host_starved}, 32'd1);
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("starved_sticky", {31'd0, host_starved}, 32'd1);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    chk("starved_cleared", {31'd0, host_starved}, 32'd0);

`ifdef FB_ARB_STATS_EN
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, '0, 1'b1, 1'b1, AW'(16'h0200 + i), DW'(i + 1));
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, AW'(16'h0300 + i), 1'b1, 1'b0, 16'h0050, 8'h00);
      @(negedge clk);
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("grant_cnt", {16'd0, host_grant_cnt}, 32'd10);
    chk("defer_cnt", {16'd0, host_defer_cnt}, 32'd5);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    chk("grant_cnt_clr", {16'd0, host_grant_cnt}, 32'd0);
    chk("defer_cnt_clr", {16'd0, host_defer_cnt}, 32'd0);
`endif
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    chk("drain_starve", sb.size(), 32'd0);

    // Reset with two reads still in flight.
    drive(1'b1, 16'h0040, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 1'b0, 16'h0041, '0);
    @(negedge clk);
    disp_req = 1'b0; host_valid = 1'b1; host_we = 1'b1; host_addr = 16'h0007; host_wdata = 8'hEE;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_host_ready", {31'd0, host_ready}, 32'd0);
    chk("midrst_rvalid", {30'd0, disp_rvalid, host_rvalid}, 32'd0);
    chk("midrst_rdata", {16'd0, disp_rdata, host_rdata}, 32'd0);
    @(negedge clk);
    host_valid = 1'b0; host_we = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_rvalid", {30'd0, disp_rvalid, host_rvalid}, 32'd0);
    end
    chk("rst_no_write", {24'd0, mem[16'h0007]}, {24'd0, init_val(16'h0007)});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
